// File: rtl/div_sqrt_iter_core.sv
// -----------------------------------------------------------------------------
// div_sqrt_iter_core
//
// Iterative radix-2 mantissa divide / square-root engine. Up to U restoring
// steps are chained combinationally per clock. The engine produces N = P+2
// result bits, left-aligned in Quot_DO, and a sticky bit that flags a nonzero
// final partial remainder. Rounding, exponents and special cases are handled
// by the surrounding unit.
//
// Ports
//   Clk_CI        clock
//   Rst_RI        synchronous reset, active high
//   Start_SI      start request, accepted while Ready_SO=1
//   Kill_SI       abort; back to idle next cycle, outputs untouched
//   Div_SI        1 = divide, 0 = square root
//   Odd_SI        sqrt: radicand is Mant_a_DI * 2
//   Precision_SI  result precision P (0 or >MANT_W means MANT_W)
//   Units_SI      steps per cycle minus one, clamped to MAX_UNITS
//   Mant_a_DI     dividend / radicand mantissa (normalized)
//   Mant_b_DI     divisor mantissa (normalized, ignored for sqrt)
//   Ready_SO      idle or finishing, can accept Start
//   Done_SO       one-cycle pulse, result valid
//   Quot_DO       left-aligned quotient / root
//   Sticky_SO     final partial remainder nonzero
// -----------------------------------------------------------------------------
module div_sqrt_iter_core #(
   parameter int MANT_W    = 53,
   parameter int MAX_UNITS = 4,
   parameter int PC_W      = 6
) (
   input  logic              Clk_CI,
   input  logic              Rst_RI,
   input  logic              Start_SI,
   input  logic              Kill_SI,
   input  logic              Div_SI,
   input  logic              Odd_SI,
   input  logic [PC_W-1:0]   Precision_SI,
   input  logic [1:0]        Units_SI,
   input  logic [MANT_W-1:0] Mant_a_DI,
   input  logic [MANT_W-1:0] Mant_b_DI,
   output logic              Ready_SO,
   output logic              Done_SO,
   output logic [MANT_W+1:0] Quot_DO,
   output logic              Sticky_SO
);

   localparam int RW = MANT_W + 4;                      // partial remainder
   localparam int QW = MANT_W + 2;                      // result bits, max N
   localparam int XW = MANT_W + 1;                      // radicand, 2 int bits
   localparam int CW = $clog2(QW + MAX_UNITS + 1);      // bit counter

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t          state_q, state_n;
   logic            div_q;
   logic [CW-1:0]   n_q, cnt_q;
   logic [2:0]      u_q;
   logic [MANT_W-1:0] b_q;
   logic [RW-1:0]   r_q;
   logic [QW-1:0]   q_q;
   logic [XW-1:0]   x_q;
   logic [QW-1:0]   quot_q;
   logic            sticky_q;

   logic [CW-1:0]   n_start;
   logic [2:0]      u_start;
   logic [RW-1:0]   b_ext, r_c, rr, t;
   logic [QW-1:0]   q_c;
   logic [XW-1:0]   x_c;
   logic [CW-1:0]   steps;
   logic            ge;
   logic            start_acc, finish;

   assign b_ext = {{(RW-MANT_W){1'b0}}, b_q};

   // Operation length and units per cycle derived from the start-cycle inputs.
   always_comb begin
      if (Precision_SI == '0 || int'(Precision_SI) > MANT_W)
         n_start = CW'(QW);
      else
         n_start = CW'(Precision_SI) + CW'(2);
      u_start = {1'b0, Units_SI} + 3'd1;
      if (int'(u_start) > MAX_UNITS)
         u_start = 3'(MAX_UNITS);
   end

   // Chain of up to MAX_UNITS restoring steps. A unit is active only if it is
   // within U and still below the remaining bit count, so the last cycle
   // commits exactly the outstanding steps.
   always_comb begin
      // NOTE: every variable gets a default before any conditional update so
      // no latch is inferred; blocking assignments let each unit see the
      // result of the previous one within the same cycle.
      r_c   = r_q;
      q_c   = q_q;
      x_c   = x_q;
      steps = '0;
      ge    = 1'b0;
      rr    = '0;
      t     = '0;
      for (int i = 0; i < MAX_UNITS; i++) begin
         if (i < int'(u_q) && (cnt_q + CW'(i)) < n_q) begin
            if (div_q) begin
               ge = (r_c >= b_ext);
               if (ge)
                  r_c = r_c - b_ext;
               r_c = r_c << 1;
            end else begin
               // Bring down the next radicand bit pair, trial value 4Q+1.
               rr  = {r_c[RW-3:0], x_c[XW-1 -: 2]};
               t   = {q_c, 2'b01};
               ge  = (rr >= t);
               r_c = ge ? rr - t : rr;
               x_c = x_c << 2;
            end
            q_c   = {q_c[QW-2:0], ge};
            steps = steps + CW'(1);
         end
      end
   end

   // Start is possible whenever the engine is not iterating; Kill overrides.
   assign start_acc = Start_SI && !Kill_SI && (state_q != S_ITER);
   assign finish    = (state_q == S_ITER) && !Kill_SI && ((cnt_q + steps) == n_q);

   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:  if (start_acc) state_n = S_ITER;
         S_ITER:  if (finish)    state_n = S_DONE;
         S_DONE:  state_n = start_acc ? S_ITER : S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (Kill_SI)
         state_n = S_IDLE;
   end

   always_ff @(posedge Clk_CI) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples values from before this edge.
      if (Rst_RI) begin
         state_q  <= S_IDLE;
         div_q    <= 1'b0;
         n_q      <= '0;
         cnt_q    <= '0;
         u_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         q_q      <= '0;
         x_q      <= '0;
         quot_q   <= '0;
         sticky_q <= 1'b0;
      end else begin
         state_q <= state_n;
         if (start_acc) begin
            div_q <= Div_SI;
            n_q   <= n_start;
            u_q   <= u_start;
            b_q   <= Mant_b_DI;
            r_q   <= Div_SI ? {{(RW-MANT_W){1'b0}}, Mant_a_DI} : '0;
            q_q   <= '0;
            x_q   <= Odd_SI ? {Mant_a_DI, 1'b0} : {1'b0, Mant_a_DI};
            cnt_q <= '0;
         end else if (state_q == S_ITER && !Kill_SI) begin
            r_q   <= r_c;
            q_q   <= q_c;
            x_q   <= x_c;
            cnt_q <= cnt_q + steps;
         end
         if (finish) begin
            // Left-align the N generated bits, zeros below.
            quot_q   <= q_c << (CW'(QW) - n_q);
            sticky_q <= |r_c;
         end
      end
   end

   assign Ready_SO  = (state_q != S_ITER);
   assign Done_SO   = (state_q == S_DONE);
   assign Quot_DO   = quot_q;
   assign Sticky_SO = sticky_q;

endmodule

// File: doc/div_sqrt_iter_core.md
# div_sqrt_iter_core

Iterative mantissa divide/square-root engine for the div/sqrt unit, parametrised in mantissa width and in the number of radix-2 iteration units chained per cycle. It generates a precision-limited, left-aligned quotient or root plus a sticky bit. Operand unpacking, special cases, exponent arithmetic and rounding (C_RM_*) stay in the surrounding top, which drives this core with a start/ready/done handshake.

## Interface
- MANT_W, 53: mantissa width including hidden bit (53 FP64, 24 FP32, 11 FP16, 8 FP16alt)
- MAX_UNITS, 4: iteration units instantiated per cycle (1..4)
- PC_W, 6: precision-control width (C_PC)
- Clk_CI  in  1  clock
- Rst_RI  in  1  synchronous reset, active high
- Start_SI  in  1  start request, accepted only while Ready_SO=1
- Kill_SI  in  1  abort current operation
- Div_SI  in  1  1 = divide, 0 = square root (sampled at start)
- Odd_SI  in  1  sqrt only: radicand is Mant_a × 2 (odd unbiased exponent)
- Precision_SI  in  PC_W  result precision P in bits
- Units_SI  in  2  units used per cycle U = Units_SI+1, clamped to MAX_UNITS
- Mant_a_DI  in  MANT_W  dividend / radicand mantissa, MSB = hidden bit
- Mant_b_DI  in  MANT_W  divisor mantissa; ignored for sqrt
- Ready_SO  out  1  idle, can accept Start
- Done_SO  out  1  one-cycle pulse, result valid
- Quot_DO  out  MANT_W+2  quotient/root, left-aligned, MSB = first generated bit
- Sticky_SO  out  1  final partial remainder nonzero

## Operation
- Clock Clk_CI; reset is synchronous and active high.
- FSM: IDLE -> ITER on accepted Start; ITER -> DONE when the bit count reaches N; DONE -> IDLE, or DONE -> ITER if Start is accepted in DONE.
- Precision: P = Precision_SI; P=0 or P>MANT_W is treated as MANT_W. N = P+2 bits are generated (integer/leading bit + guard).
- Start latches Div_SI, Odd_SI, N, U and operands. Operands must be normalized (MSB=1); anything else is outside the contract.
- Divide (restoring): R0 = A, width MANT_W+4 internal. Per step: q = (R >= B); if q then R -= B; append q; R <<= 1. The first bit is the integer bit of A/B in (0.5, 2).
- Sqrt (restoring digit recurrence): the radicand X = Odd ? {Mant_a,0} : {0,Mant_a} has 2 integer bits and is zero-extended to 2N bits. Start with R=0, Q=0. Per step: R = (R<<2) | next two X bits; T = (Q<<2)|1; if R >= T then R -= T and Q = (Q<<1)|1, else Q = Q<<1. The root lies in [1,2).
- Each ITER cycle chains U steps combinationally. The final cycle commits only the N - done remaining steps; extra units are masked.
- Quot_DO[MANT_W+1 -: N] holds the result bits. The lower MANT_W+2-N bits are 0. Sticky_SO = (final R != 0).
- Quot_DO and Sticky_SO update only at the DONE transition and hold until the next DONE.
- Kill_SI in any state returns to IDLE next cycle, with no Done_SO and outputs unchanged. Kill wins over a simultaneous Start.
- Start while Ready_SO=0 is ignored.

## Timing
- Reset values: Ready_SO=1, Done_SO=0, Quot_DO=0, Sticky_SO=0, FSM=IDLE, counters 0.
- Start high at edge k: Ready_SO=0 from cycle k+1, ITER occupies ceil(N/U) cycles, and Done_SO=1 in cycle k+ceil(N/U)+1.
- Ready_SO returns to 1 in the DONE cycle, so back-to-back operation has one DONE cycle between ITER bursts.
- A Start in the DONE cycle is accepted. Its ITER begins the next cycle and does not corrupt the current outputs.
- Reset asserted mid-ITER: the next cycle is in reset state and no Done_SO follows.
- Inputs other than Kill_SI are ignored outside the start cycle.

## Test plan
- Div, MANT_W=53, P=53, U=4, A=1.5, B=1.0 -> Done_SO 15 cycles after Start; Quot_DO = 11 followed by 53 zeros; Sticky=0.
- Div, U=1, P=10, A=1.0, B=1.5 -> Done 13 cycles after Start; Quot_DO top 12 bits = 010101010101, lower bits 0; Sticky=1.
- Sqrt, Odd=1, A=1.125 (radicand 2.25), P=24, U=3 -> root 1.1: Quot_DO = 11 followed by zeros; Sticky=0; Done after ceil(26/3)+1 = 10 cycles.
- Sqrt, Odd=0, A=1.0 -> Quot_DO MSB=1, rest 0, Sticky=0. Sqrt, Odd=1, A=1.0 -> leading bits 1011010100000100 (√2), Sticky=1.
- Kill_SI pulsed mid-ITER, together with a simultaneous Start -> no Done_SO; Ready_SO=1 the next cycle; outputs keep previous values; a following Start completes normally.
- Start during ITER ignored. Start in the DONE cycle -> second Done_SO exactly ceil(N/U)+1 cycles later. Rst_RI mid-op -> all outputs at reset values the next cycle.
